// File: rtl/lsu_sbuf_pipe.sv
// lsu_sbuf_pipe: pipeline load/store unit with posted store buffer; STORE_FWD_EN enables store-to-load forwarding
module lsu_sbuf_pipe #(
  parameter int SB_DEPTH = 4,
  parameter int TAG_W = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_result,
  input  logic [2:0]        in_funct3,
  input  logic              in_mem_ren,
  input  logic              in_mem_wen,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_misalign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  output logic              sb_empty
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = ADDR_W - 2;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t state, state_nxt;
  logic [WA-1:0] sb_addr [SB_DEPTH];
  logic [31:0] sb_data [SB_DEPTH];
  logic [3:0] sb_mask [SB_DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] sb_count;
  logic drain_busy;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0] ld_funct3;
  logic [TAG_W-1:0] ld_tag;
  logic [1:0] off;
  logic [3:0] in_mask;
  logic mis, any_match, fwd_hit, slot_free, op_ok, accept, push, pop, ld_start;
  logic drain_req, load_req, drain_fire, load_fire, ld_rsp;
  logic [31:0] acc_result;
`ifdef STORE_FWD_EN
  logic [3:0] fwd_mask;
  logic [31:0] fwd_data;
`endif

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] o, input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {o, 3'b000};
    return f3[1] ? s :
           f3[0] ? (f3[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]}) :
                   (f3[2] ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]});
  endfunction

  assign off = in_addr[1:0];
  assign in_mask = in_funct3[1] ? 4'b1111 : in_funct3[0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
  assign mis = (in_mem_ren || in_mem_wen) &&
               ((in_funct3[1:0] == 2'b01 && off[0]) || (in_funct3[1] && off != 2'b00));

  // Walk oldest to youngest so the last hit is the youngest matching entry
  always_comb begin
    any_match = 1'b0;
    idx = head;
`ifdef STORE_FWD_EN
    fwd_mask = 4'b0;
    fwd_data = 32'b0;
`endif
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < sb_count && sb_addr[idx] == in_addr[ADDR_W-1:2]) begin
        any_match = 1'b1;
`ifdef STORE_FWD_EN
        fwd_mask = sb_mask[idx];
        fwd_data = sb_data[idx];
`endif
      end
    end
  end

`ifdef STORE_FWD_EN
  assign fwd_hit = any_match && ((fwd_mask & in_mask) == in_mask);
  assign acc_result = (mis || in_mem_wen) ? 32'b0 : in_mem_ren ? load_ext(fwd_data, off, in_funct3) : in_result;
`else
  assign fwd_hit = 1'b0;
  assign acc_result = (mis || in_mem_wen || in_mem_ren) ? 32'b0 : in_result;
`endif

  assign slot_free = (!out_valid || out_ready) && state == IDLE;
  assign op_ok = mis ? 1'b1 : in_mem_ren ? (!any_match || fwd_hit) : in_mem_wen ? (sb_count < CW'(SB_DEPTH)) : 1'b1;
  assign in_ready = slot_free && !flush && op_ok;
  assign accept = in_valid && in_ready;
  assign push = accept && in_mem_wen && !mis;
  assign ld_start = accept && in_mem_ren && !mis && !fwd_hit;
  assign drain_req = state == IDLE && sb_count != '0 && !drain_busy;
  assign load_req = state == REQ && !drain_busy;
  assign drain_fire = drain_req && mem_req_ready;
  assign load_fire = load_req && mem_req_ready;
  assign pop = drain_busy && mem_rsp_valid;
  assign ld_rsp = state == WAIT && mem_rsp_valid;
  assign sb_empty = sb_count == '0;
  assign mem_req_valid = drain_req || load_req;
  assign mem_req_wen = drain_req;
  assign mem_req_addr = drain_req ? {sb_addr[head], 2'b00} : load_req ? {ld_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_req_wdata = drain_req ? sb_data[head] : 32'b0;
  assign mem_req_wmask = drain_req ? sb_mask[head] : 4'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = ld_start ? REQ : IDLE;
      REQ: state_nxt = load_fire ? (flush ? DROP : WAIT) : (flush ? IDLE : REQ);
      WAIT: state_nxt = mem_rsp_valid ? IDLE : (flush ? DROP : WAIT);
      DROP: state_nxt = mem_rsp_valid ? IDLE : DROP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_result <= 32'b0;
      out_tag <= '0;
      out_misalign <= 1'b0;
      head <= '0;
      tail <= '0;
      sb_count <= '0;
      drain_busy <= 1'b0;
      ld_addr <= '0;
      ld_funct3 <= 3'b0;
      ld_tag <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (ld_rsp) begin
        out_valid <= 1'b1;
        out_result <= load_ext(mem_rsp_rdata, ld_addr[1:0], ld_funct3);
        out_tag <= ld_tag;
        out_misalign <= 1'b0;
      end else if (accept && !ld_start) begin
        out_valid <= 1'b1;
        out_result <= acc_result;
        out_tag <= in_tag;
        out_misalign <= mis;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ld_start) begin
        ld_addr <= in_addr;
        ld_funct3 <= in_funct3;
        ld_tag <= in_tag;
      end
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      sb_count <= sb_count + CW'(push) - CW'(pop);
      drain_busy <= drain_fire ? 1'b1 : pop ? 1'b0 : drain_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= in_addr[ADDR_W-1:2];
      sb_data[tail] <= in_wdata << {off, 3'b000};
      sb_mask[tail] <= in_mask;
    end
  end
endmodule

// File: tb/tb_lsu_sbuf_pipe.sv
// tb_lsu_sbuf_pipe: directed self-checking bench for lsu_sbuf_pipe
module tb_lsu_sbuf_pipe;
  logic clk = 0, rst, flush, in_valid, in_ready, in_mem_ren, in_mem_wen;
  logic [31:0] in_addr, in_wdata, in_result, out_result, mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [2:0] in_funct3;
  logic [7:0] in_tag, out_tag;
  logic out_valid, out_ready, out_misalign, mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, sb_empty;
  logic [3:0] mem_req_wmask;
  int total = 0, bad = 0;

  lsu_sbuf_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result), .in_funct3(in_funct3),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_misalign(out_misalign), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [7:0] tg);
    in_valid = 1; in_mem_ren = ren; in_mem_wen = wen; in_funct3 = f3; in_addr = a; in_wdata = d; in_tag = tg;
  endtask

  task automatic load_seq(input string nm, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] rsp, input logic [31:0] exp);
    drive(1, 0, f3, a, 0, 8'h5A);
    #1 chk({nm, "_rdy"}, in_ready, 1);
    cyc();
    in_valid = 0; mem_req_ready = 1;
    #1 chk({nm, "_req"}, mem_req_valid, 1);
    chk({nm, "_req_wen"}, mem_req_wen, 0);
    chk({nm, "_req_addr"}, mem_req_addr, a & 32'hFFFF_FFFC);
    cyc();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = rsp;
    #1 chk({nm, "_early"}, out_valid, 0);
    cyc();
    mem_rsp_valid = 0;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_data"}, out_result, exp);
    chk({nm, "_tag"}, out_tag, 8'h5A);
    cyc();
  endtask

  task automatic store_drain(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_data, input logic [3:0] exp_mask);
    drive(0, 1, f3, a, d, 8'h21);
    #1 chk({nm, "_rdy"}, in_ready, 1);
    cyc();
    in_valid = 0;
    chk({nm, "_retire"}, out_valid, 1);
    chk({nm, "_res0"}, out_result, 0);
    chk({nm, "_dvalid"}, mem_req_valid, 1);
    chk({nm, "_dwen"}, mem_req_wen, 1);
    chk({nm, "_daddr"}, mem_req_addr, a & 32'hFFFF_FFFC);
    chk({nm, "_ddata"}, mem_req_wdata, exp_data);
    chk({nm, "_dmask"}, mem_req_wmask, exp_mask);
    mem_req_ready = 1;
    cyc();
    mem_req_ready = 0; mem_rsp_valid = 1;
    cyc();
    mem_rsp_valid = 0;
    chk({nm, "_empty"}, sb_empty, 1);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_mem_ren = 0; in_mem_wen = 0; in_addr = 0; in_wdata = 0;
    in_result = 0; in_funct3 = 0; in_tag = 0; out_ready = 1; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_misalign", out_misalign, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_wen", mem_req_wen, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_wmask", mem_req_wmask, 0);
    chk("rst_sb_empty", sb_empty, 1);
    rst = 0;
    cyc();
    // plain result passthrough with output backpressure
    drive(0, 0, 3'b000, 0, 0, 8'h3C); in_result = 32'hA5A5_A5A5;
    #1 chk("alu_rdy", in_ready, 1);
    cyc();
    in_valid = 0; out_ready = 0;
    chk("alu_valid", out_valid, 1);
    chk("alu_result", out_result, 32'hA5A5_A5A5);
    chk("alu_tag", out_tag, 8'h3C);
    cyc();
    chk("alu_hold", out_valid, 1);
    drive(0, 0, 3'b000, 0, 0, 8'h3D); in_result = 32'h1;
    #1 chk("alu_bp_rdy", in_ready, 0);
    out_ready = 1;
    #1 chk("alu_bp_rdy2", in_ready, 1);
    cyc();
    in_valid = 0;
    chk("alu2_result", out_result, 1);
    cyc();
    chk("alu_drained", out_valid, 0);
    // flush kills a pending result
    drive(0, 0, 3'b000, 0, 0, 8'h01); out_ready = 0;
    cyc();
    in_valid = 0; flush = 1;
    #1 chk("flush_rdy", in_ready, 0);
    cyc();
    flush = 0; out_ready = 1;
    chk("flush_clear", out_valid, 0);
    // load extension
    load_seq("lb", 32'h8000_0003, 3'b000, 32'h80AA_BBCC, 32'hFFFF_FF80);
    load_seq("lhu", 32'h8000_0002, 3'b101, 32'h80AA_BBCC, 32'h0000_80AA);
    load_seq("lh", 32'h8000_0002, 3'b001, 32'h80AA_BBCC, 32'hFFFF_80AA);
    load_seq("lbu", 32'h8000_0001, 3'b100, 32'h80AA_BBCC, 32'h0000_00BB);
    // misaligned ops
    drive(1, 0, 3'b010, 32'h102, 0, 8'h44);
    #1 chk("mis_lw_rdy", in_ready, 1);
    chk("mis_lw_noreq", mem_req_valid, 0);
    cyc();
    chk("mis_lw_valid", out_valid, 1);
    chk("mis_lw_flag", out_misalign, 1);
    chk("mis_lw_res", out_result, 0);
    chk("mis_lw_noreq2", mem_req_valid, 0);
    chk("mis_lw_empty", sb_empty, 1);
    drive(0, 1, 3'b010, 32'h101, 32'hFFFF_FFFF, 8'h45);
    cyc();
    in_valid = 0;
    chk("mis_sw_flag", out_misalign, 1);
    chk("mis_sw_empty", sb_empty, 1);
    chk("mis_sw_noreq", mem_req_valid, 0);
    cyc();
    // lane placement
    store_drain("sb", 3'b000, 32'h501, 32'h0000_00AB, 32'h0000_AB00, 4'b0010);
    store_drain("sh", 3'b001, 32'h502, 32'h1234_BEEF, 32'hBEEF_0000, 4'b1100);
    store_drain("sw", 3'b010, 32'h504, 32'h1234_5678, 32'h1234_5678, 4'b1111);
    // buffer full: fifth store waits for the first ack
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 3'b010, 32'h300 + 4 * i, i, 8'h60);
      #1 chk("full_rdy", in_ready, 1);
      cyc();
      chk("full_retire", out_valid, 1);
    end
    drive(0, 1, 3'b010, 32'h310, 4, 8'h64);
    #1 chk("full_5th_blocked", in_ready, 0);
    chk("full_head_addr", mem_req_addr, 32'h300);
    mem_req_ready = 1;
    cyc();
    mem_req_ready = 0;
    chk("full_still_blocked", in_ready, 0);
    mem_rsp_valid = 1;
    cyc();
    mem_rsp_valid = 0;
    #1 chk("full_5th_rdy", in_ready, 1);
    cyc();
    in_valid = 0;
    chk("full_5th_retire", out_valid, 1);
    chk("full_5th_tag", out_tag, 8'h64);
    for (int j = 0; j < 4; j++) begin
      chk("full_drain_valid", mem_req_valid, 1);
      chk("full_drain_addr", mem_req_addr, 32'h304 + 4 * j);
      chk("full_drain_data", mem_req_wdata, j + 1);
      mem_req_ready = 1;
      cyc();
      mem_req_ready = 0; mem_rsp_valid = 1;
      cyc();
      mem_rsp_valid = 0;
    end
    chk("full_empty", sb_empty, 1);
    // store then load to the same word
    drive(0, 1, 3'b010, 32'h100, 32'h1234_5678, 8'h70);
    cyc();
    drive(1, 0, 3'b010, 32'h100, 0, 8'h77);
`ifdef STORE_FWD_EN
    #1 chk("fwd_rdy", in_ready, 1);
    cyc();
    in_valid = 0;
    chk("fwd_valid", out_valid, 1);
    chk("fwd_data", out_result, 32'h1234_5678);
    chk("fwd_tag", out_tag, 8'h77);
    chk("fwd_no_load_req", mem_req_wen, 1);
    mem_req_ready = 1;
    cyc();
    mem_req_ready = 0; mem_rsp_valid = 1;
    cyc();
    mem_rsp_valid = 0;
    chk("fwd_empty", sb_empty, 1);
`else
    #1 chk("raw_stall", in_ready, 0);
    chk("raw_drain_wen", mem_req_wen, 1);
    chk("raw_drain_data", mem_req_wdata, 32'h1234_5678);
    mem_req_ready = 1;
    cyc();
    mem_req_ready = 0;
    chk("raw_stall_head", in_ready, 0);
    mem_rsp_valid = 1;
    cyc();
    mem_rsp_valid = 0;
    #1 chk("raw_rdy", in_ready, 1);
    cyc();
    in_valid = 0; mem_req_ready = 1;
    chk("raw_req_valid", mem_req_valid, 1);
    chk("raw_req_wen", mem_req_wen, 0);
    chk("raw_req_addr", mem_req_addr, 32'h100);
    cyc();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h1234_5678;
    cyc();
    mem_rsp_valid = 0;
    chk("raw_valid", out_valid, 1);
    chk("raw_data", out_result, 32'h1234_5678);
    chk("raw_tag", out_tag, 8'h77);
`endif
    cyc();
    // flush while the load waits for its response
    drive(1, 0, 3'b010, 32'h400, 0, 8'h11);
    cyc();
    in_valid = 0; mem_req_ready = 1;
    chk("fl_req", mem_req_valid, 1);
    cyc();
    mem_req_ready = 0; flush = 1;
    cyc();
    flush = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hDEAD_BEEF;
    cyc();
    mem_rsp_valid = 0;
    chk("fl_drop", out_valid, 0);
    cyc();
    chk("fl_drop2", out_valid, 0);
    load_seq("fl_next", 32'h404, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D);
    // reset with two buffered stores and a drain outstanding
    mem_req_ready = 1;
    drive(0, 1, 3'b010, 32'h200, 1, 8'h80);
    cyc();
    drive(0, 1, 3'b010, 32'h204, 2, 8'h81);
    #1 chk("rd_req_addr", mem_req_addr, 32'h200);
    cyc();
    in_valid = 0;
    chk("rd_pre_valid", out_valid, 1);
    chk("rd_pre_nonempty", sb_empty, 0);
    chk("rd_pre_outstanding", mem_req_valid, 0);
    rst = 1;
    #1 chk("rd_empty", sb_empty, 1);
    chk("rd_req_valid", mem_req_valid, 0);
    chk("rd_out_valid", out_valid, 0);
    cyc();
    rst = 0;
    cyc();
    chk("rd_after_empty", sb_empty, 1);
    chk("rd_after_req", mem_req_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
